// File: rtl/store_unit_if.sv
// Store unit bus bundle: issue side from the register-read stage and the
// request/acknowledge side towards data memory.
interface store_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              issue_valid;
    logic              issue_ready;
    logic [31:0]       instruction;
    logic [31:0]       Read_data1;
    logic [31:0]       Read_data2;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic              mem_ack;
    logic              store_fault;
    logic [ADDR_W-1:0] fault_addr;
    logic [CNT_W-1:0]  buf_count;

    // Store unit side
    modport slave (
        input  issue_valid, instruction, Read_data1, Read_data2, mem_ack,
        output issue_ready, mem_req, mem_addr, mem_wdata, mem_be,
               store_fault, fault_addr, buf_count
    );

    // Pipeline / memory side
    modport master (
        output issue_valid, instruction, Read_data1, Read_data2, mem_ack,
        input  issue_ready, mem_req, mem_addr, mem_wdata, mem_be,
               store_fault, fault_addr, buf_count
    );
endinterface

// File: rtl/store_unit.sv
// SB/SH/SW store datapath: effective address, byte-lane data/enables,
// store buffer FIFO and a req/ack drain state machine towards data memory.
//
//   state | meaning
//   IDLE  | no request outstanding, waiting for a buffered store
//   REQ   | head entry presented on mem_req, waiting for mem_ack
module store_unit #(
    parameter int ADDR_W     = 32,
    parameter int DEPTH      = 4,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input logic         clk,
    input logic         reset,
    store_unit_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [5:0] OP_SB = 6'h28;
    localparam logic [5:0] OP_SH = 6'h29;
    localparam logic [5:0] OP_SW = 6'h2B;

    typedef enum logic {IDLE, REQ} state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              fault_q;
    logic [ADDR_W-1:0] fault_addr_q;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [31:0]       data_mem [DEPTH];
    logic [3:0]        be_mem   [DEPTH];

    logic [5:0]        opcode;
    logic signed [15:0] imm;
    logic [ADDR_W-1:0] ea;
    logic [1:0]        lane;
    logic              is_store;
    logic              misaligned;
    logic [31:0]       st_data;
    logic [3:0]        st_be;
    logic              accept;
    logic              enq;
    logic              pop;
    logic              fault_d;
    logic              unused_instr_bits;

    assign unused_instr_bits = ^bus.instruction[25:16];

    // Decode, effective address and byte-lane generation for the issued store
    always_comb begin
        opcode     = bus.instruction[31:26];
        imm        = signed'(bus.instruction[15:0]);
        ea         = bus.Read_data1[ADDR_W-1:0] + ADDR_W'(imm);
        // big-endian lane is 3-k, which for two bits is the bitwise inverse
        lane       = BIG_ENDIAN ? ~ea[1:0] : ea[1:0];
        is_store   = 1'b0;
        misaligned = 1'b0;
        st_data    = bus.Read_data2;
        st_be      = 4'b0000;
        case (opcode)
            OP_SB: begin
                is_store = 1'b1;
                st_data  = {4{bus.Read_data2[7:0]}};
                st_be    = 4'b0001 << lane;
            end
            OP_SH: begin
                is_store   = 1'b1;
                misaligned = ea[0];
                st_data    = {2{bus.Read_data2[15:0]}};
                st_be      = (ea[1] ^ BIG_ENDIAN) ? 4'b1100 : 4'b0011;
            end
            OP_SW: begin
                is_store   = 1'b1;
                misaligned = |ea[1:0];
                st_be      = 4'b1111;
            end
            default: ;
        endcase
    end

    assign bus.issue_ready = (count_q != CNT_W'(DEPTH));
    assign accept          = bus.issue_valid & bus.issue_ready;
    assign enq             = accept & is_store & ~misaligned;
    assign fault_d         = accept & is_store & misaligned;
    assign pop             = (state_q == REQ) & bus.mem_ack;

    // Pointers, occupancy, fault pulse and drain state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            state_q <= state_d;
            if (enq) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(enq) - CNT_W'(pop);
            fault_q <= fault_d;
            if (fault_d) fault_addr_q <= ea;
        end
    end

    // Buffer storage; contents need no reset since occupancy gates their use
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_mem[wr_ptr_q] <= {ea[ADDR_W-1:2], 2'b00};
            data_mem[wr_ptr_q] <= st_data;
            be_mem[wr_ptr_q]   <= st_be;
        end
    end

    // Drain next-state: REQ holds the head until acked, leaves when it popped the last entry
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (count_q != '0) state_d = REQ;
            REQ:  if (bus.mem_ack && count_q <= CNT_W'(1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_req     = (state_q == REQ);
    assign bus.mem_addr    = addr_mem[rd_ptr_q];
    assign bus.mem_wdata   = data_mem[rd_ptr_q];
    assign bus.mem_be      = be_mem[rd_ptr_q];
    assign bus.store_fault = fault_q;
    assign bus.fault_addr  = fault_addr_q;
    assign bus.buf_count   = count_q;
endmodule

// File: tb/tb_store_unit.sv
// Bench for store_unit: a little-endian and a big-endian instance receive the
// same stimulus; a reference model fills per-instance expectation queues and
// a monitor compares every memory handshake, fault pulse and occupancy.
module tb_store_unit;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 4;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        issue_valid = 1'b0;
    logic [31:0] instruction = '0;
    logic [31:0] rs_v = '0;
    logic [31:0] rt_v = '0;
    logic        mem_ack = 1'b0;

    store_unit_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) if_le ();
    store_unit_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) if_be ();

    assign if_le.issue_valid = issue_valid;
    assign if_le.instruction = instruction;
    assign if_le.Read_data1  = rs_v;
    assign if_le.Read_data2  = rt_v;
    assign if_le.mem_ack     = mem_ack;
    assign if_be.issue_valid = issue_valid;
    assign if_be.instruction = instruction;
    assign if_be.Read_data1  = rs_v;
    assign if_be.Read_data2  = rt_v;
    assign if_be.mem_ack     = mem_ack;

    store_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BIG_ENDIAN(1'b0)) u_le (
        .clk(clk), .reset(reset), .bus(if_le.slave));
    store_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BIG_ENDIAN(1'b1)) u_be (
        .clk(clk), .reset(reset), .bus(if_be.slave));

    exp_t        q_le[$];
    exp_t        q_be[$];
    logic [31:0] fq_le[$];
    logic [31:0] fq_be[$];
    int n_pass = 0;
    int n_total = 0;
    int ack_mode = 0;     // 0 never, 1 always, 2 random
    bit ack_once = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: byte offsets of the access mapped to lanes by endianness
    function automatic void model_accept(input logic [31:0] instr, input logic [31:0] rs,
                                         input logic [31:0] rt);
        logic [31:0] ea;
        logic [15:0] imm;
        int size, off;
        exp_t e_le, e_be;
        imm = instr[15:0];
        ea = rs + {{16{imm[15]}}, imm};
        case (instr[31:26])
            6'h28:   size = 1;
            6'h29:   size = 2;
            6'h2B:   size = 4;
            default: size = 0;
        endcase
        if (size == 0) return;
        off = int'(ea % 4);
        if (off % size != 0) begin
            fq_le.push_back(ea);
            fq_be.push_back(ea);
            return;
        end
        e_le.be = 4'b0000;
        e_be.be = 4'b0000;
        for (int b = off; b < off + size; b++) begin
            e_le.be[b]     = 1'b1;
            e_be.be[3 - b] = 1'b1;
        end
        if (size == 1)      e_le.data = {4{rt[7:0]}};
        else if (size == 2) e_le.data = {2{rt[15:0]}};
        else                e_le.data = rt;
        e_le.addr = ea - (ea % 4);
        e_be.addr = e_le.addr;
        e_be.data = e_le.data;
        q_le.push_back(e_le);
        q_be.push_back(e_be);
    endfunction

    // Called just after a rising edge; returns number of edges stalled by issue_ready=0
    task automatic issue(input logic [5:0] op, input logic [31:0] rs, input logic [15:0] imm,
                         input logic [31:0] rt, output int waited);
        logic [9:0] junk;
        junk = 10'($urandom);
        instruction = {op, junk, imm};
        rs_v = rs;
        rt_v = rt;
        issue_valid = 1'b1;
        waited = 0;
        forever begin
            @(negedge clk);
            #2;
            if (if_le.issue_ready) break;
            waited++;
            if (waited >= 200) break;
        end
        if (waited >= 200) begin
            check("issue_timeout", 64'd0, 64'd1);
            @(posedge clk);
            #1;
            issue_valid = 1'b0;
        end else begin
            @(posedge clk);
            model_accept(instruction, rs_v, rt_v);
            #1;
            issue_valid = 1'b0;
        end
    endtask

    // Acknowledge driver and scoreboard monitor, both away from the rising edge
    always @(negedge clk) begin
        if (ack_once) begin
            mem_ack = 1'b1;
            ack_once = 1'b0;
        end else begin
            case (ack_mode)
                1:       mem_ack = 1'b1;
                2:       mem_ack = ($urandom_range(0, 2) != 0);
                default: mem_ack = 1'b0;
            endcase
        end
        #1;
        if (reset) begin
            check("le_count", 64'(if_le.buf_count), 64'(q_le.size()));
            check("le_ready", 64'(if_le.issue_ready), 64'(q_le.size() != DEPTH));
            if (q_le.size() == 0) check("le_req_empty", 64'(if_le.mem_req), 64'd0);
            else if (if_le.mem_req) begin
                check("le_addr", 64'(if_le.mem_addr), 64'(q_le[0].addr));
                check("le_wdata", 64'(if_le.mem_wdata), 64'(q_le[0].data));
                check("le_be", 64'(if_le.mem_be), 64'(q_le[0].be));
                if (mem_ack) void'(q_le.pop_front());
            end
            if (if_le.store_fault) begin
                if (fq_le.size() == 0) check("le_fault_spurious", 64'd1, 64'd0);
                else check("le_fault_addr", 64'(if_le.fault_addr), 64'(fq_le.pop_front()));
            end else if (fq_le.size() != 0) begin
                check("le_fault_missing", 64'd0, 64'd1);
                void'(fq_le.pop_front());
            end

            check("be_count", 64'(if_be.buf_count), 64'(q_be.size()));
            if (q_be.size() == 0) check("be_req_empty", 64'(if_be.mem_req), 64'd0);
            else if (if_be.mem_req) begin
                check("be_addr", 64'(if_be.mem_addr), 64'(q_be[0].addr));
                check("be_wdata", 64'(if_be.mem_wdata), 64'(q_be[0].data));
                check("be_be", 64'(if_be.mem_be), 64'(q_be[0].be));
                if (mem_ack) void'(q_be.pop_front());
            end
            if (if_be.store_fault) begin
                if (fq_be.size() == 0) check("be_fault_spurious", 64'd1, 64'd0);
                else check("be_fault_addr", 64'(if_be.fault_addr), 64'(fq_be.pop_front()));
            end else if (fq_be.size() != 0) begin
                check("be_fault_missing", 64'd0, 64'd1);
                void'(fq_be.pop_front());
            end
        end
    end

    task automatic drain(input string name);
        int n;
        ack_mode = 1;
        n = 0;
        while ((q_le.size() != 0 || q_be.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, 64'(q_le.size() + q_be.size()), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        int r;
        logic [5:0] op;
        logic [31:0] rs;

        repeat (3) @(posedge clk);
        #1;
        check("rst_count", 64'(if_le.buf_count), 64'd0);
        check("rst_ready", 64'(if_le.issue_ready), 64'd1);
        check("rst_req", 64'(if_le.mem_req), 64'd0);
        check("rst_fault", 64'(if_le.store_fault), 64'd0);
        check("rst_fault_addr", 64'(if_le.fault_addr), 64'd0);
        @(negedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // directed: SW, SB at offset 3, SH with negative imm, misaligned SH
        ack_mode = 1;
        issue(6'h2B, 32'h1000, 16'h0004, 32'hDEADBEEF, w);
        issue(6'h28, 32'h2003, 16'h0000, 32'h000000A5, w);
        issue(6'h29, 32'h3002, 16'hFFFE, 32'h00001234, w);
        issue(6'h29, 32'h3001, 16'h0000, 32'h00001234, w);
        issue(6'h23, 32'h4000, 16'h0000, 32'h11111111, w);
        drain("drain_directed");

        // fill with ack held off, then one ack with the fifth store waiting
        ack_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) issue(6'h2B, 32'h5000 + 32'(i * 4), 16'h0000, 32'hA0 + 32'(i), w);
        check("full_ready", 64'(if_le.issue_ready), 64'd0);
        check("full_count", 64'(if_le.buf_count), 64'd4);
        ack_once = 1'b1;
        issue(6'h2B, 32'h5010, 16'h0000, 32'hA4, w);
        check("full_pop_then_accept", 64'(w), 64'd1);
        check("refill_count", 64'(if_le.buf_count), 64'd4);
        drain("drain_full");

        // reset in the middle of a drain
        ack_mode = 0;
        for (int i = 0; i < 3; i++) issue(6'h2B, 32'h6000 + 32'(i * 4), 16'h0000, 32'hB0 + 32'(i), w);
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_req", 64'(if_le.mem_req), 64'd1);
        reset = 1'b0;
        q_le.delete();
        q_be.delete();
        fq_le.delete();
        fq_be.delete();
        #1;
        check("mid_rst_req", 64'(if_le.mem_req), 64'd0);
        check("mid_rst_count", 64'(if_le.buf_count), 64'd0);
        check("mid_rst_ready", 64'(if_le.issue_ready), 64'd1);
        @(negedge clk);
        #3;
        reset = 1'b1;
        ack_mode = 1;
        repeat (4) @(posedge clk);
        #1;
        issue(6'h2B, 32'h7000, 16'h0008, 32'hC0FFEE00, w);
        drain("drain_after_reset");

        // randomized traffic with random acknowledge
        ack_mode = 2;
        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(0, 7);
            case (r)
                0, 1:    op = 6'h28;
                2, 3:    op = 6'h29;
                4, 5:    op = 6'h2B;
                default: op = 6'($urandom);
            endcase
            rs = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 15));
            issue(op, rs, 16'($urandom), $urandom, w);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        drain("drain_random");
        repeat (3) @(posedge clk);
        #1;
        check("faults_seen", 64'(fq_le.size() + fq_be.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
